// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and imem (slave).
// A transfer happens on any cycle where imem_req and imem_ack are both high.
interface fetch_stage_if #(
   parameter int PC_W   = 12,
   parameter int INST_W = 16
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues single-outstanding imem reads and buffers
// returned words in a 2-entry queue whose head is the IF/ID word seen by decode.
module fetch_stage #(
   parameter int                PC_W     = 12,
   parameter int                INST_W   = 16,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input  logic              clk,
   input  logic              rst,
   fetch_stage_if.master     imem,
   input  logic              stallD_i,
   input  logic              branch_taken_i,
   input  logic [PC_W-1:0]   PC_branch_i,
   output logic [INST_W-1:0] instD_o,
   output logic [PC_W-1:0]   pcD_o,
   output logic              validD_o
);

   typedef enum logic [1:0] {
      S_BOOT     = 2'd0,
      S_RUN      = 2'd1,
      S_REDIRECT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [1:0]        count_q, count_d;
   logic [PC_W-1:0]   qpc_q   [2];
   logic [PC_W-1:0]   qpc_d   [2];
   logic [INST_W-1:0] qinst_q [2];
   logic [INST_W-1:0] qinst_d [2];

   logic in_run;
   logic valid;
   logic pop;
   logic req;
   logic redirect;
   logic push;
   logic wr_slot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_BOOT:     state_d = S_RUN;
         S_RUN:      if (branch_taken_i) state_d = S_REDIRECT;
         S_REDIRECT: state_d = S_RUN;
         default:    state_d = S_BOOT;
      endcase
   end

   // A full queue may only request again when its head leaves this same cycle.
   always_comb begin
      in_run   = (state_q == S_RUN);
      valid    = (count_q != 2'd0) && (state_q != S_REDIRECT);
      pop      = valid && !stallD_i;
      req      = in_run && ((count_q < 2'd2) || pop);
      redirect = in_run && branch_taken_i;
      push     = req && imem.imem_ack && !redirect;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      qpc_d      = qpc_q;
      qinst_d    = qinst_q;
      wr_slot    = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
      if (redirect) begin
         fetch_pc_d = PC_branch_i;
         count_d    = 2'd0;
      end else begin
         if (pop) begin
            qpc_d[0]   = qpc_q[1];
            qinst_d[0] = qinst_q[1];
         end
         if (push) begin
            qpc_d[wr_slot]   = fetch_pc_q;
            qinst_d[wr_slot] = imem.imem_rdata;
            fetch_pc_d       = fetch_pc_q + PC_W'(1);
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            qpc_q[i]   <= '0;
            qinst_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         for (int i = 0; i < 2; i++) begin
            qpc_q[i]   <= qpc_d[i];
            qinst_q[i] <= qinst_d[i];
         end
      end
   end

   // With nothing to present, pcD tracks the address that will be fetched next.
   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc_q;
   assign validD_o       = valid;
   assign instD_o        = valid ? qinst_q[0] : NOP_INST;
   assign pcD_o          = valid ? qpc_q[0] : fetch_pc_q;

endmodule
